// File: rtl/encoder_8b10b_multi.sv
// Multi-lane 8b/10b encoder: NUM_SYMBOLS bytes per clock, running disparity chained
// lane-to-lane and word-to-word, with one registered valid/ready output stage.
module encoder_8b10b_multi #(
  parameter int   NUM_SYMBOLS  = 1,
  parameter logic RD_RESET_NEG = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [8*NUM_SYMBOLS-1:0]  data_i,
  input  logic [NUM_SYMBOLS-1:0]    is_k_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic                      rd_init_i,
  output logic [10*NUM_SYMBOLS-1:0] data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [NUM_SYMBOLS-1:0]    k_err_o,
  output logic                      rd_neg_o
);

  // 5b/6b code (abcdei, a = MSB) as seen from RD-; the RD+ form is derived by complement.
  function automatic logic [5:0] code6_neg(input logic [4:0] x);
    logic [5:0] c;
    case (x)
      5'd0:    c = 6'b100111;
      5'd1:    c = 6'b011101;
      5'd2:    c = 6'b101101;
      5'd3:    c = 6'b110001;
      5'd4:    c = 6'b110101;
      5'd5:    c = 6'b101001;
      5'd6:    c = 6'b011001;
      5'd7:    c = 6'b111000;
      5'd8:    c = 6'b111001;
      5'd9:    c = 6'b100101;
      5'd10:   c = 6'b010101;
      5'd11:   c = 6'b110100;
      5'd12:   c = 6'b001101;
      5'd13:   c = 6'b101100;
      5'd14:   c = 6'b011100;
      5'd15:   c = 6'b010111;
      5'd16:   c = 6'b011011;
      5'd17:   c = 6'b100011;
      5'd18:   c = 6'b010011;
      5'd19:   c = 6'b110010;
      5'd20:   c = 6'b001011;
      5'd21:   c = 6'b101010;
      5'd22:   c = 6'b011010;
      5'd23:   c = 6'b111010;
      5'd24:   c = 6'b110011;
      5'd25:   c = 6'b100110;
      5'd26:   c = 6'b010110;
      5'd27:   c = 6'b110110;
      5'd28:   c = 6'b001110;
      5'd29:   c = 6'b101110;
      5'd30:   c = 6'b011110;
      default: c = 6'b101011;
    endcase
    return c;
  endfunction

  // 3b/4b code (fghj, f = MSB) from RD-; y = 7 returns the primary P7 form.
  function automatic logic [3:0] code4_neg(input logic [2:0] y);
    logic [3:0] c;
    case (y)
      3'd0:    c = 4'b1011;
      3'd1:    c = 4'b1001;
      3'd2:    c = 4'b0101;
      3'd3:    c = 4'b1100;
      3'd4:    c = 4'b1101;
      3'd5:    c = 4'b1010;
      3'd6:    c = 4'b0110;
      default: c = 4'b1110;
    endcase
    return c;
  endfunction

  // Returns {k_err, rd_neg_end, abcdei, fghj} for one byte entered at rd_neg.
  function automatic logic [11:0] encode_symbol(input logic [7:0] byte_v,
                                                input logic       k,
                                                input logic       rd_neg);
    logic [4:0] x;
    logic [2:0] y;
    logic       k28;
    logic       k_legal;
    logic       unbal6;
    logic       unbal4;
    logic       rd_mid;
    logic       use_a7;
    logic       rd_end;
    logic [5:0] c6;
    logic [3:0] c4;
    x       = byte_v[4:0];
    y       = byte_v[7:5];
    k28     = k && (x == 5'd28);
    k_legal = k28 || (k && (y == 3'd7) &&
              ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30)));

    c6     = k28 ? 6'b001111 : code6_neg(x);
    unbal6 = ($countones(c6) != 3);
    // D.7 is neutral but still has distinct RD-/RD+ forms.
    if (!rd_neg && (unbal6 || (x == 5'd7))) c6 = ~c6;
    rd_mid = unbal6 ? !rd_neg : rd_neg;

    // A7 avoids a run of five identical bits across the sub-block boundary.
    use_a7 = (y == 3'd7) &&
             (k_legal ||
              (rd_mid  && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
              (!rd_mid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));
    c4     = use_a7 ? 4'b0111 : code4_neg(y);
    unbal4 = ($countones(c4) != 2);
    if (!rd_mid && (unbal4 || (y == 3'd3))) c4 = ~c4;
    // K28 balanced 4b codes flip with the entry RD so the comma stays unique.
    if (k28 && !rd_neg && ((y == 3'd1) || (y == 3'd2) || (y == 3'd5) || (y == 3'd6)))
      c4 = ~c4;
    rd_end = unbal4 ? !rd_mid : rd_mid;
    return {k && !k_legal, rd_end, c6, c4};
  endfunction

  logic                      rd_q;
  logic                      rd_chain;
  logic                      accept;
  logic [11:0]               sym;
  logic [10*NUM_SYMBOLS-1:0] enc_data;
  logic [NUM_SYMBOLS-1:0]    enc_kerr;

  // Handshake: a word transfers on any edge where valid and ready are both high;
  // the output register holds data_o/k_err_o/valid_o steady while valid_o && !ready_i,
  // and can be refilled in the same cycle it is drained.
  assign ready_o = !valid_o || ready_i;
  assign accept  = valid_i && ready_o;

  always_comb begin
    enc_data = '0;
    enc_kerr = '0;
    sym      = '0;
    rd_chain = rd_init_i ? RD_RESET_NEG : rd_q;
    for (int i = 0; i < NUM_SYMBOLS; i++) begin
      sym                 = encode_symbol(data_i[8*i +: 8], is_k_i[i], rd_chain);
      enc_data[10*i +: 10] = sym[9:0];
      enc_kerr[i]         = sym[11];
      rd_chain            = sym[10];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o  <= '0;
      k_err_o <= '0;
      valid_o <= 1'b0;
      rd_q    <= RD_RESET_NEG;
    end else if (accept) begin
      data_o  <= enc_data;
      k_err_o <= enc_kerr;
      valid_o <= 1'b1;
      rd_q    <= rd_chain;
    end else begin
      if (ready_i) valid_o <= 1'b0;
      if (rd_init_i) rd_q <= RD_RESET_NEG;
    end
  end

  assign rd_neg_o = rd_q;

endmodule

// File: tb/tb_encoder_8b10b_multi.sv
// Bench for encoder_8b10b_multi: a 1-lane and a 4-lane instance, each with a driver,
// an expected-word queue filled from a table-driven 8b/10b model, and a monitor.
module tb_encoder_8b10b_multi;

  // clock / reset
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  data1_i = '0;
  logic [0:0]  is_k1_i = '0;
  logic        valid1_i = 1'b0, rd_init1_i = 1'b0, ready1_i = 1'b1;
  logic        ready1_o, valid1_o, rd_neg1_o;
  logic [9:0]  data1_o;
  logic [0:0]  k_err1_o;

  logic [31:0] data4_i = '0;
  logic [3:0]  is_k4_i = '0;
  logic        valid4_i = 1'b0, rd_init4_i = 1'b0, ready4_i = 1'b1;
  logic        ready4_o, valid4_o, rd_neg4_o;
  logic [39:0] data4_o;
  logic [3:0]  k_err4_o;

  encoder_8b10b_multi #(.NUM_SYMBOLS(1), .RD_RESET_NEG(1'b1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_i), .data_i(data1_i), .is_k_i(is_k1_i),
    .valid_i(valid1_i), .ready_o(ready1_o), .rd_init_i(rd_init1_i),
    .data_o(data1_o), .valid_o(valid1_o), .ready_i(ready1_i),
    .k_err_o(k_err1_o), .rd_neg_o(rd_neg1_o));

  encoder_8b10b_multi #(.NUM_SYMBOLS(4), .RD_RESET_NEG(1'b1)) u_dut4 (
    .clk_i(clk), .rst_i(rst_i), .data_i(data4_i), .is_k_i(is_k4_i),
    .valid_i(valid4_i), .ready_o(ready4_o), .rd_init_i(rd_init4_i),
    .data_o(data4_o), .valid_o(valid4_o), .ready_i(ready4_i),
    .k_err_o(k_err4_o), .rd_neg_o(rd_neg4_o));

  // reference tables (RD- and RD+ columns written out in full)
  logic [5:0] d6_neg [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  logic [5:0] d6_pos [32] = '{
    6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
    6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
    6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
  logic [3:0] d4_neg [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  logic [3:0] d4_pos [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
  logic [7:0] k_byte [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                              8'hF7, 8'hFB, 8'hFD, 8'hFE};
  logic [9:0] k_neg [12] = '{
    10'b0011110100, 10'b0011111001, 10'b0011110101, 10'b0011110011, 10'b0011110010,
    10'b0011111010, 10'b0011110110, 10'b0011111000, 10'b1110101000, 10'b1101101000,
    10'b1011101000, 10'b0111101000};
  logic [9:0] k_pos [12] = '{
    10'b1100001011, 10'b1100000110, 10'b1100001010, 10'b1100001100, 10'b1100001101,
    10'b1100000101, 10'b1100001001, 10'b1100000111, 10'b0001010111, 10'b0010010111,
    10'b0100010111, 10'b1000010111};
  logic [4:0] a7_x [6] = '{5'd11, 5'd13, 5'd14, 5'd17, 5'd18, 5'd20};

  // scoreboard state
  int         checks = 0;
  int         errors = 0;
  logic       started = 1'b0;
  logic       model_rd1 = 1'b1;
  logic       model_rd4 = 1'b1;
  logic [10:0] exp1_q[$];
  logic [43:0] exp4_q[$];
  logic [10:0] mon_item1;
  logic [43:0] mon_item4;
  int         bp_mode = 0;
  logic       force_ready = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic ref_encode(input logic [7:0] b, input logic k, input logic rd_neg,
                            output logic [9:0] code, output logic kerr, output logic rd_out);
    int         idx;
    int         x;
    int         y;
    logic       mid;
    logic [5:0] s6;
    logic [3:0] s4;
    idx = -1;
    for (int i = 0; i < 12; i++) if (k && (k_byte[i] == b)) idx = i;
    kerr = k && (idx < 0);
    x = int'(b[4:0]);
    y = int'(b[7:5]);
    if (idx >= 0) begin
      code = rd_neg ? k_neg[idx] : k_pos[idx];
    end else begin
      s6  = rd_neg ? d6_neg[x] : d6_pos[x];
      mid = ($countones(s6) == 3) ? rd_neg : !rd_neg;
      if (y == 7 && ((mid && (x == 17 || x == 18 || x == 20)) ||
                     (!mid && (x == 11 || x == 13 || x == 14))))
        s4 = mid ? 4'b0111 : 4'b1000;
      else
        s4 = mid ? d4_neg[y] : d4_pos[y];
      code = {s6, s4};
    end
    rd_out = ($countones(code) == 5) ? rd_neg : !rd_neg;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drivers: called at posedge+1, return at posedge+1 after the accepting edge
  task automatic send1(input logic [7:0] b, input logic k, input logic init);
    logic [9:0] code;
    logic       kerr;
    logic       rd_n;
    logic       accepted;
    int         waited;
    data1_i = b; is_k1_i = k; rd_init1_i = init; valid1_i = 1'b1;
    accepted = 1'b0; waited = 0;
    while (!accepted && waited < 64) begin
      @(negedge clk);
      if (ready1_o) begin
        ref_encode(b, k, init ? 1'b1 : model_rd1, code, kerr, rd_n);
        @(posedge clk);
        exp1_q.push_back({kerr, code});
        model_rd1 = rd_n;
        accepted = 1'b1;
      end else begin
        @(posedge clk);
        if (init) model_rd1 = 1'b1;
        waited++;
      end
    end
    if (!accepted) check("send1_timeout", 64'd0, 64'd1);
    #1;
    valid1_i = 1'b0; rd_init1_i = 1'b0;
  endtask

  task automatic send4(input logic [31:0] w, input logic [3:0] k, input logic init);
    logic [39:0] code_w;
    logic [3:0]  kerr_w;
    logic [9:0]  code;
    logic        kerr;
    logic        rd;
    logic        accepted;
    int          waited;
    data4_i = w; is_k4_i = k; rd_init4_i = init; valid4_i = 1'b1;
    accepted = 1'b0; waited = 0;
    while (!accepted && waited < 64) begin
      @(negedge clk);
      if (ready4_o) begin
        rd = init ? 1'b1 : model_rd4;
        for (int i = 0; i < 4; i++) begin
          ref_encode(w[8*i +: 8], k[i], rd, code, kerr, rd);
          code_w[10*i +: 10] = code;
          kerr_w[i] = kerr;
        end
        @(posedge clk);
        exp4_q.push_back({kerr_w, code_w});
        model_rd4 = rd;
        accepted = 1'b1;
      end else begin
        @(posedge clk);
        if (init) model_rd4 = 1'b1;
        waited++;
      end
    end
    if (!accepted) check("send4_timeout", 64'd0, 64'd1);
    #1;
    valid4_i = 1'b0; rd_init4_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(posedge clk);
    exp1_q.delete();
    exp4_q.delete();
    model_rd1 = 1'b1;
    model_rd4 = 1'b1;
    #1;
    rst_i = 1'b0;
  endtask

  task automatic rand_sym(output logic [7:0] b, output logic k);
    int r;
    r = $urandom_range(0, 7);
    k = 1'b0;
    b = 8'($urandom_range(0, 255));
    case (r)
      0: begin k = 1'b1; b = k_byte[$urandom_range(0, 11)]; end
      1: k = 1'b1;
      2: begin b[7:5] = 3'd7; b[4:0] = a7_x[$urandom_range(0, 5)]; end
      default: ;
    endcase
  endtask

  // ready_i generators
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (bp_mode)
        0: begin ready1_i = 1'b1; ready4_i = 1'b1; end
        1: begin
          ready1_i = ($urandom_range(0, 3) != 0);
          ready4_i = ($urandom_range(0, 3) != 0);
        end
        default: begin ready1_i = force_ready; ready4_i = 1'b1; end
      endcase
    end
  end

  // monitors
  always @(negedge clk) begin
    if (started) begin
      check("valid1", valid1_o, exp1_q.size() != 0);
      check("ready1", ready1_o, (exp1_q.size() == 0) || ready1_i);
      check("rd1", rd_neg1_o, model_rd1);
      if (valid1_o && exp1_q.size() != 0) begin
        mon_item1 = exp1_q[0];
        check("data1", data1_o, mon_item1[9:0]);
        check("kerr1", k_err1_o, mon_item1[10]);
        if (ready1_i) void'(exp1_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("valid4", valid4_o, exp4_q.size() != 0);
      check("ready4", ready4_o, (exp4_q.size() == 0) || ready4_i);
      check("rd4", rd_neg4_o, model_rd4);
      if (valid4_o && exp4_q.size() != 0) begin
        mon_item4 = exp4_q[0];
        check("data4", data4_o, mon_item4[39:0]);
        check("kerr4", k_err4_o, mon_item4[43:40]);
        if (ready4_i) void'(exp4_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    check("watchdog", 64'd0, 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [7:0] b;
    logic       k;
    logic [31:0] w;
    logic [3:0]  kw;
    step();
    do_reset();
    started = 1'b1;
    @(negedge clk);
    check("rst_data1", data1_o, 10'd0);
    check("rst_kerr1", k_err1_o, 1'b0);
    check("rst_data4", data4_o, 40'd0);
    check("rst_rd4", rd_neg4_o, 1'b1);
    step();

    // single-lane directed words
    send1(8'h00, 1'b0, 1'b0);
    @(negedge clk); check("d0_0", data1_o, 10'b1001110100); check("d0_0_rd", rd_neg1_o, 1'b1);
    step();
    send1(8'hBC, 1'b1, 1'b0);
    @(negedge clk); check("k28_5_neg", data1_o, 10'b0011111010); check("k28_5_rd", rd_neg1_o, 1'b0);
    step();
    send1(8'hBC, 1'b1, 1'b0);
    @(negedge clk); check("k28_5_pos", data1_o, 10'b1100000101); check("k28_5_rd2", rd_neg1_o, 1'b1);
    step();
    send1(8'hF1, 1'b0, 1'b0);
    @(negedge clk); check("d17_7_neg", data1_o, 10'b1000110111); check("d17_7_rd", rd_neg1_o, 1'b0);
    step();
    send1(8'hF1, 1'b0, 1'b0);
    @(negedge clk); check("d17_7_pos", data1_o, 10'b1000110001); check("d17_7_rd2", rd_neg1_o, 1'b1);
    step();
    send1(8'h00, 1'b1, 1'b0);
    @(negedge clk); check("bad_k_data", data1_o, 10'b1001110100); check("bad_k_err", k_err1_o, 1'b1);
    step();
    send1(8'hBC, 1'b1, 1'b0);
    step();
    send1(8'h00, 1'b0, 1'b1);
    @(negedge clk); check("init_word", data1_o, 10'b1001110100);
    step();
    send1(8'hBC, 1'b1, 1'b0);
    rd_init1_i = 1'b1;
    @(posedge clk);
    model_rd1 = 1'b1;
    #1 rd_init1_i = 1'b0;
    @(negedge clk); check("init_idle_rd", rd_neg1_o, 1'b1);
    step();

    // four-lane chaining
    send4(32'hBC00BC00, 4'b1010, 1'b0);
    @(negedge clk);
    check("n4_word", data4_o, {10'b1100000101, 10'b0110001011, 10'b0011111010, 10'b1001110100});
    check("n4_rd", rd_neg4_o, 1'b1);
    step();

    // backpressure hold
    bp_mode = 2; force_ready = 1'b0;
    send1(8'h55, 1'b0, 1'b0);
    fork
      send1(8'h3C, 1'b0, 1'b0);
      begin
        repeat (4) begin
          @(negedge clk);
          check("bp_ready_low", ready1_o, 1'b0);
        end
        force_ready = 1'b1;
      end
    join
    bp_mode = 0;
    repeat (3) step();

    // reset while a word is held
    bp_mode = 2; force_ready = 1'b0;
    step();
    send1(8'hBC, 1'b1, 1'b0);
    @(negedge clk); check("held_valid", valid1_o, 1'b1);
    step();
    do_reset();
    @(negedge clk); check("rst_drop_valid", valid1_o, 1'b0); check("rst_drop_rd", rd_neg1_o, 1'b1);
    bp_mode = 0;
    step();

    // randomized traffic with random backpressure
    bp_mode = 1;
    fork
      for (int n = 0; n < 300; n++) begin
        rand_sym(b, k);
        send1(b, k, $urandom_range(0, 15) == 0);
        repeat ($urandom_range(0, 2)) step();
      end
      for (int n = 0; n < 200; n++) begin
        for (int i = 0; i < 4; i++) begin
          rand_sym(b, k);
          w[8*i +: 8] = b;
          kw[i] = k;
        end
        send4(w, kw, $urandom_range(0, 15) == 0);
        repeat ($urandom_range(0, 2)) step();
      end
    join
    bp_mode = 0;
    repeat (5) step();
    check("drain1", exp1_q.size(), 0);
    check("drain4", exp4_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
